// File: rtl/dm_pkg.sv
// Shared definitions for the debug-module abstract command controller:
// DMI register map, cmderr codes, FSM states and command field positions.
package dm_pkg;

    localparam logic [6:0] DM_DATA0      = 7'h04;
    localparam logic [6:0] DM_DMCONTROL  = 7'h10;
    localparam logic [6:0] DM_DMSTATUS   = 7'h11;
    localparam logic [6:0] DM_ABSTRACTCS = 7'h16;
    localparam logic [6:0] DM_COMMAND    = 7'h17;

    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    typedef enum logic [2:0] {
        CMDERR_NONE       = 3'd0,
        CMDERR_BUSY       = 3'd1,
        CMDERR_NOTSUP     = 3'd2,
        CMDERR_EXCEPT     = 3'd3,
        CMDERR_HALTRESUME = 3'd4
    } cmderr_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    // command register fields
    localparam int CMD_TYPE_MSB  = 31;
    localparam int CMD_TYPE_LSB  = 24;
    localparam int CMD_SIZE_MSB  = 22;
    localparam int CMD_SIZE_LSB  = 20;
    localparam int CMD_POSTEXEC  = 18;
    localparam int CMD_TRANSFER  = 17;
    localparam int CMD_WRITE     = 16;
    localparam int CMD_REGNO_MSB = 15;

    localparam logic [2:0] AARSIZE_32 = 3'd2;

    // dmcontrol / abstractcs fields
    localparam int DMC_HALTREQ   = 31;
    localparam int DMC_RESUMEREQ = 30;
    localparam int DMC_DMACTIVE  = 0;
    localparam int ACS_ERR_MSB   = 10;
    localparam int ACS_ERR_LSB   = 8;

endpackage

// File: rtl/dm_abstract_ctrl.sv
// Debug module: DMI register decode, halt/resume requests and Access
// Register command sequencing towards the core's abstract register bus.
// Ports:
//   clk_i, reset_i                 clock, async active-high reset
//   dmi_req_* / dmi_op_i / addr/data  DMI request (one outstanding)
//   dmi_resp_*                     DMI response, held until accepted
//   dbg_haltreq_o, dbg_resumereq_o halt level / resume held until ack
//   core_halted_i, core_running_i, core_resumeack_i  core status
//   dbg_ar_*                       abstract register access bus
module dm_abstract_ctrl
    import dm_pkg::*;
#(
    parameter int AR_TIMEOUT = 16,
    parameter int DM_VERSION = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        dmi_req_valid_i,
    output logic        dmi_req_ready_o,
    input  logic [1:0]  dmi_op_i,
    input  logic [6:0]  dmi_addr_i,
    input  logic [31:0] dmi_data_i,
    output logic        dmi_resp_valid_o,
    input  logic        dmi_resp_ready_i,
    output logic [31:0] dmi_resp_data_o,
    output logic        dbg_haltreq_o,
    output logic        dbg_resumereq_o,
    input  logic        core_halted_i,
    input  logic        core_running_i,
    input  logic        core_resumeack_i,
    output logic        dbg_ar_en_o,
    output logic        dbg_ar_wr_o,
    output logic [15:0] dbg_ar_ad_o,
    output logic [31:0] dbg_ar_do_o,
    input  logic [31:0] dbg_ar_di_i,
    input  logic        dbg_ar_done_i
);

    localparam int CW = $clog2(AR_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(AR_TIMEOUT - 1);

    state_e        state;
    cmderr_e       cmderr;
    logic          dmactive;
    logic          haltreq;
    logic          ack_sticky;
    logic [31:0]   data0;
    logic [CW-1:0] tcnt;
    logic          busy;

    logic          req_fire;
    logic          rd_req;
    logic          wr_req;
    logic          acc_data0;
    logic          wr_dmctl;
    logic          wr_acs;
    logic          wr_cmd;
    logic          cmd_notsup;
    logic [31:0]   rd_data;
    logic [31:0]   dmstatus;
    logic [31:0]   abstractcs;
    logic [31:0]   dmcontrol;

    assign busy = (state == ST_EXEC);

    // reset also blocks acceptance so every output reads 0 in reset
    assign dmi_req_ready_o = !dmi_resp_valid_o && !reset_i;
    assign req_fire = dmi_req_valid_i && dmi_req_ready_o;
    assign rd_req   = req_fire && (dmi_op_i == DMI_OP_READ);
    assign wr_req   = req_fire && (dmi_op_i == DMI_OP_WRITE);

    assign acc_data0 = dmactive && (rd_req || wr_req)
                    && (dmi_addr_i == DM_DATA0);
    assign wr_dmctl  = wr_req && (dmi_addr_i == DM_DMCONTROL);
    assign wr_acs    = dmactive && wr_req
                    && (dmi_addr_i == DM_ABSTRACTCS);
    assign wr_cmd    = dmactive && wr_req
                    && (dmi_addr_i == DM_COMMAND);

    assign cmd_notsup =
        (dmi_data_i[CMD_TYPE_MSB:CMD_TYPE_LSB] != 8'h00)
        || (dmi_data_i[CMD_SIZE_MSB:CMD_SIZE_LSB] != AARSIZE_32)
        || dmi_data_i[CMD_POSTEXEC];

    assign dbg_haltreq_o = dmactive && haltreq;
    assign dbg_ar_do_o   = dbg_ar_en_o ? data0 : '0;

    always_comb begin
        dmstatus        = '0;
        dmstatus[3:0]   = 4'(DM_VERSION);
        dmstatus[7]     = 1'b1;
        dmstatus[9:8]   = {2{core_halted_i}};
        dmstatus[11:10] = {2{core_running_i}};
        dmstatus[17:16] = {2{ack_sticky}};

        abstractcs        = '0;
        abstractcs[3:0]   = 4'd1;
        abstractcs[10:8]  = cmderr;
        abstractcs[12]    = busy;

        dmcontrol                = '0;
        dmcontrol[DMC_HALTREQ]   = haltreq;
        dmcontrol[DMC_DMACTIVE]  = dmactive;

        rd_data = '0;
        unique case (1'b1)
            dmi_addr_i == DM_DATA0:      rd_data = data0;
            dmi_addr_i == DM_DMCONTROL:  rd_data = dmcontrol;
            dmi_addr_i == DM_DMSTATUS:   rd_data = dmstatus;
            dmi_addr_i == DM_ABSTRACTCS: rd_data = abstractcs;
            default:                     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dmi_resp_valid_o <= 1'b0;
            dmi_resp_data_o  <= '0;
            dbg_resumereq_o  <= 1'b0;
            dbg_ar_en_o      <= 1'b0;
            dbg_ar_wr_o      <= 1'b0;
            dbg_ar_ad_o      <= '0;
            state            <= ST_IDLE;
            cmderr           <= CMDERR_NONE;
            dmactive         <= 1'b0;
            haltreq          <= 1'b0;
            ack_sticky       <= 1'b0;
            data0            <= '0;
            tcnt             <= '0;
        end else begin
            if (req_fire) begin
                dmi_resp_valid_o <= 1'b1;
                dmi_resp_data_o  <= rd_req ? rd_data : '0;
            end else if (dmi_resp_valid_o && dmi_resp_ready_i) begin
                dmi_resp_valid_o <= 1'b0;
                dmi_resp_data_o  <= '0;
            end

            if (dbg_resumereq_o && core_resumeack_i) begin
                dbg_resumereq_o <= 1'b0;
                ack_sticky      <= 1'b1;
            end

            if (wr_dmctl) begin
                dmactive <= dmi_data_i[DMC_DMACTIVE];
                if (dmactive) begin
                    haltreq <= dmi_data_i[DMC_HALTREQ];
                    // a write asking for halt suppresses resume
                    if (dmi_data_i[DMC_RESUMEREQ]
                        && !dmi_data_i[DMC_HALTREQ]) begin
                        dbg_resumereq_o <= 1'b1;
                        ack_sticky      <= 1'b0;
                    end
                end
            end

            if (wr_acs) begin
                cmderr <= cmderr_e'(cmderr
                    & ~dmi_data_i[ACS_ERR_MSB:ACS_ERR_LSB]);
            end

            if (acc_data0) begin
                if (busy) begin
                    cmderr <= CMDERR_BUSY;
                end else if (wr_req) begin
                    data0 <= dmi_data_i;
                end
            end

            if (wr_cmd) begin
                if (busy) begin
                    cmderr <= CMDERR_BUSY;
                end else if (cmderr == CMDERR_NONE) begin
                    if (cmd_notsup) begin
                        cmderr <= CMDERR_NOTSUP;
                    end else if (!core_halted_i) begin
                        cmderr <= CMDERR_HALTRESUME;
                    end else if (dmi_data_i[CMD_TRANSFER]) begin
                        state       <= ST_EXEC;
                        dbg_ar_en_o <= 1'b1;
                        dbg_ar_wr_o <= dmi_data_i[CMD_WRITE];
                        dbg_ar_ad_o <= dmi_data_i[CMD_REGNO_MSB:0];
                        tcnt        <= '0;
                    end
                end
            end

            // core completion / timeout override any DMI effect this cycle
            unique case (state)
                ST_EXEC: begin
                    if (dbg_ar_done_i) begin
                        if (!dbg_ar_wr_o) begin
                            data0 <= dbg_ar_di_i;
                        end
                        state       <= ST_IDLE;
                        dbg_ar_en_o <= 1'b0;
                        dbg_ar_wr_o <= 1'b0;
                        dbg_ar_ad_o <= '0;
                    end else if (tcnt == TMO_LAST) begin
                        cmderr      <= CMDERR_EXCEPT;
                        state       <= ST_IDLE;
                        dbg_ar_en_o <= 1'b0;
                        dbg_ar_wr_o <= 1'b0;
                        dbg_ar_ad_o <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase

            // inactive DM: everything but dmactive is held cleared
            if (!dmactive) begin
                data0           <= '0;
                cmderr          <= CMDERR_NONE;
                haltreq         <= 1'b0;
                dbg_resumereq_o <= 1'b0;
                ack_sticky      <= 1'b0;
                state           <= ST_IDLE;
                dbg_ar_en_o     <= 1'b0;
                dbg_ar_wr_o     <= 1'b0;
                dbg_ar_ad_o     <= '0;
                tcnt            <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dm_abstract_ctrl.sv
// Bench for dm_abstract_ctrl: transaction-level model checked every
// cycle plus directed DMI sequences with literal expectations.
module tb_dm_abstract_ctrl;

    localparam int AR_TIMEOUT = 16;
    localparam logic [1:0] RD = 2'd1;
    localparam logic [1:0] WR = 2'd2;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        dmi_req_valid_i = 1'b0;
    logic        dmi_req_ready_o;
    logic [1:0]  dmi_op_i = 2'd0;
    logic [6:0]  dmi_addr_i = 7'd0;
    logic [31:0] dmi_data_i = 32'd0;
    logic        dmi_resp_valid_o;
    logic        dmi_resp_ready_i = 1'b1;
    logic [31:0] dmi_resp_data_o;
    logic        dbg_haltreq_o;
    logic        dbg_resumereq_o;
    logic        core_halted_i = 1'b0;
    logic        core_running_i = 1'b1;
    logic        core_resumeack_i = 1'b0;
    logic        dbg_ar_en_o;
    logic        dbg_ar_wr_o;
    logic [15:0] dbg_ar_ad_o;
    logic [31:0] dbg_ar_do_o;
    logic [31:0] dbg_ar_di_i = 32'd0;
    logic        dbg_ar_done_i = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_abstract_ctrl #(
        .AR_TIMEOUT(AR_TIMEOUT),
        .DM_VERSION(2)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .dmi_req_valid_i(dmi_req_valid_i),
        .dmi_req_ready_o(dmi_req_ready_o),
        .dmi_op_i(dmi_op_i),
        .dmi_addr_i(dmi_addr_i),
        .dmi_data_i(dmi_data_i),
        .dmi_resp_valid_o(dmi_resp_valid_o),
        .dmi_resp_ready_i(dmi_resp_ready_i),
        .dmi_resp_data_o(dmi_resp_data_o),
        .dbg_haltreq_o(dbg_haltreq_o),
        .dbg_resumereq_o(dbg_resumereq_o),
        .core_halted_i(core_halted_i),
        .core_running_i(core_running_i),
        .core_resumeack_i(core_resumeack_i),
        .dbg_ar_en_o(dbg_ar_en_o),
        .dbg_ar_wr_o(dbg_ar_wr_o),
        .dbg_ar_ad_o(dbg_ar_ad_o),
        .dbg_ar_do_o(dbg_ar_do_o),
        .dbg_ar_di_i(dbg_ar_di_i),
        .dbg_ar_done_i(dbg_ar_done_i)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_act = 0, m_halt = 0, m_res = 0, m_ack = 0;
    bit          m_busy = 0, m_cwr = 0, m_rv = 0;
    logic [15:0] m_reg = '0;
    logic [31:0] m_d0 = '0, m_rsp = '0;
    logic [2:0]  m_err = '0;
    int          m_left = 0;
    bit          mf, mrd, mwr, mwb, mwa, mto;
    logic [2:0]  mwe;

    function automatic logic [31:0] m_read(input logic [6:0] a);
        case (a)
            7'h04: return m_d0;
            7'h10: return {m_halt, 30'b0, m_act};
            7'h11: return 32'h82
                        | (core_halted_i  ? 32'h300   : 32'h0)
                        | (core_running_i ? 32'hC00   : 32'h0)
                        | (m_ack          ? 32'h30000 : 32'h0);
            7'h16: return 32'h1 | (32'(m_err) << 8)
                        | (m_busy ? 32'h1000 : 32'h0);
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            m_act = 0; m_halt = 0; m_res = 0; m_ack = 0;
            m_busy = 0; m_cwr = 0; m_rv = 0; m_reg = '0;
            m_d0 = '0; m_rsp = '0; m_err = '0; m_left = 0;
        end else begin
            mf  = dmi_req_valid_i && !m_rv;
            mrd = mf && dmi_op_i == RD;
            mwr = mf && dmi_op_i == WR;
            mwb = m_busy; mwa = m_act; mwe = m_err; mto = 0;
            if (mf) begin
                m_rv = 1;
                m_rsp = mrd ? m_read(dmi_addr_i) : 32'h0;
            end else if (m_rv && dmi_resp_ready_i) begin
                m_rv = 0; m_rsp = 0;
            end
            if (m_res && core_resumeack_i) begin
                m_res = 0; m_ack = 1;
            end
            if (mwb) begin
                if (dbg_ar_done_i) begin
                    if (!m_cwr) m_d0 = dbg_ar_di_i;
                    m_busy = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 0; mto = 1;
                    end
                end
            end
            if (mwa && (mrd || mwr) && dmi_addr_i == 7'h04) begin
                if (mwb) m_err = 1;
                else if (mwr) m_d0 = dmi_data_i;
            end
            if (mwa && mwr && dmi_addr_i == 7'h16)
                m_err = m_err & ~dmi_data_i[10:8];
            if (mwa && mwr && dmi_addr_i == 7'h17) begin
                if (mwb) m_err = 1;
                else if (mwe == 0) begin
                    if (dmi_data_i[31:24] != 0 || dmi_data_i[22:20] != 2
                        || dmi_data_i[18]) m_err = 2;
                    else if (!core_halted_i) m_err = 4;
                    else if (dmi_data_i[17]) begin
                        m_busy = 1; m_left = AR_TIMEOUT;
                        m_cwr = dmi_data_i[16];
                        m_reg = dmi_data_i[15:0];
                    end
                end
            end
            if (mto) m_err = 3;
            if (mwr && dmi_addr_i == 7'h10) begin
                m_act = dmi_data_i[0];
                if (mwa) begin
                    m_halt = dmi_data_i[31];
                    if (dmi_data_i[30] && !dmi_data_i[31]) begin
                        m_res = 1; m_ack = 0;
                    end
                end
            end
            if (!mwa) begin
                m_d0 = 0; m_err = 0; m_halt = 0; m_res = 0;
                m_ack = 0; m_busy = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("req_ready", 32'(dmi_req_ready_o), 32'(!m_rv && !reset_i));
        chk("resp_valid", 32'(dmi_resp_valid_o), 32'(m_rv));
        if (m_rv) chk("resp_data", dmi_resp_data_o, m_rsp);
        chk("haltreq", 32'(dbg_haltreq_o), 32'(m_act && m_halt));
        chk("resumereq", 32'(dbg_resumereq_o), 32'(m_res));
        chk("ar_en", 32'(dbg_ar_en_o), 32'(m_busy));
        chk("ar_wr", 32'(dbg_ar_wr_o), 32'(m_busy && m_cwr));
        chk("ar_ad", 32'(dbg_ar_ad_o), m_busy ? 32'(m_reg) : 32'h0);
        chk("ar_do", dbg_ar_do_o, m_busy ? m_d0 : 32'h0);
    end

    // ---------------- core responder ----------------
    int          done_delay = -1;
    int          en_cnt = 0;
    int          en_total = 0;
    logic [15:0] last_ad = '0;
    logic        last_wr = 1'b0;
    logic [31:0] last_do = '0;

    always @(negedge clk) begin
        if (dbg_ar_en_o) begin
            dbg_ar_done_i = (done_delay >= 0) && (en_cnt >= done_delay);
            en_cnt++;
            en_total++;
            last_ad = dbg_ar_ad_o;
            last_wr = dbg_ar_wr_o;
            last_do = dbg_ar_do_o;
        end else begin
            en_cnt = 0;
            dbg_ar_done_i = 1'b0;
        end
    end

    // ---------------- DMI driver ----------------
    task automatic dmi(input logic [1:0] op, input logic [6:0] addr,
                       input logic [31:0] data, output logic [31:0] rdata);
        int n;
        dmi_req_valid_i = 1'b1;
        dmi_op_i   = op;
        dmi_addr_i = addr;
        dmi_data_i = data;
        @(posedge clk);
        #1;
        dmi_req_valid_i = 1'b0;
        dmi_op_i = 2'd0;
        n = 0;
        while (!dmi_resp_valid_o && n < 4) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 4) chk("resp_timeout", 32'(n), 32'(0));
        rdata = dmi_resp_data_o;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] r;
    int          n0;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_haltreq", 32'(dbg_haltreq_o), 0);
        chk("rst_resume", 32'(dbg_resumereq_o), 0);
        chk("rst_en", 32'(dbg_ar_en_o), 0);
        chk("rst_rvalid", 32'(dmi_resp_valid_o), 0);
        reset_i = 1'b0;

        dmi(RD, 7'h16, 0, r); chk("acs_reset", r, 32'h1);
        dmi(RD, 7'h11, 0, r); chk("dmstatus_run", r, 32'hC82);

        dmi(WR, 7'h10, 32'h80000001, r);
        chk("halt_inactive", 32'(dbg_haltreq_o), 0);
        dmi(WR, 7'h10, 32'h80000001, r);
        chk("halt_active", 32'(dbg_haltreq_o), 1);
        core_halted_i = 1'b1; core_running_i = 1'b0;
        dmi(RD, 7'h11, 0, r); chk("dmstatus_halt", r, 32'h382);

        // write x5, same-cycle done
        dmi(WR, 7'h04, 32'hDEADBEEF, r);
        done_delay = 0; n0 = en_total;
        dmi(WR, 7'h17, 32'h00231005, r);
        repeat (2) @(posedge clk);
        #1;
        chk("x5_en_cycles", en_total - n0, 1);
        chk("x5_ad", 32'(last_ad), 32'h1005);
        chk("x5_wr", 32'(last_wr), 1);
        chk("x5_do", last_do, 32'hDEADBEEF);
        dmi(RD, 7'h16, 0, r); chk("x5_acs", r, 32'h1);

        // read x2, done after 3 extra cycles
        dbg_ar_di_i = 32'h12345678; done_delay = 3;
        dmi(WR, 7'h17, 32'h00221002, r);
        dmi(RD, 7'h16, 0, r); chk("x2_busy", r, 32'h1001);
        repeat (6) @(posedge clk);
        #1;
        dmi(RD, 7'h04, 0, r); chk("x2_data0", r, 32'h12345678);
        dmi(RD, 7'h16, 0, r); chk("x2_acs", r, 32'h1);

        // running core
        core_halted_i = 1'b0; core_running_i = 1'b1; n0 = en_total;
        dmi(WR, 7'h17, 32'h00221002, r);
        dmi(RD, 7'h16, 0, r); chk("haltresume_err", r, 32'h401);
        chk("haltresume_no_en", en_total - n0, 0);
        dmi(WR, 7'h16, 32'h700, r);
        dmi(RD, 7'h16, 0, r); chk("w1c_clear", r, 32'h1);
        core_halted_i = 1'b1; core_running_i = 1'b0;

        // unsupported commands
        dmi(WR, 7'h17, 32'h01221002, r);
        dmi(RD, 7'h16, 0, r); chk("notsup_type", r, 32'h201);
        dmi(WR, 7'h16, 32'h700, r);
        dmi(WR, 7'h17, 32'h00321002, r);
        dmi(RD, 7'h16, 0, r); chk("notsup_size", r, 32'h201);
        dmi(WR, 7'h16, 32'h700, r);

        // busy errors: command and data0 write while busy
        dbg_ar_di_i = 32'hA5A50001; done_delay = 5;
        dmi(WR, 7'h17, 32'h00221002, r);
        dmi(WR, 7'h17, 32'h00221002, r);
        dmi(WR, 7'h04, 32'h11112222, r);
        repeat (6) @(posedge clk);
        #1;
        dmi(RD, 7'h04, 0, r); chk("busy_data0", r, 32'hA5A50001);
        dmi(RD, 7'h16, 0, r); chk("busy_err", r, 32'h101);
        dmi(WR, 7'h16, 32'h700, r);

        // data0 write coinciding with done
        dbg_ar_di_i = 32'h0BADF00D; done_delay = 1;
        dmi(WR, 7'h17, 32'h00221002, r);
        dmi(WR, 7'h04, 32'h55555555, r);
        repeat (3) @(posedge clk);
        #1;
        dmi(RD, 7'h04, 0, r); chk("collide_data0", r, 32'h0BADF00D);
        dmi(RD, 7'h16, 0, r); chk("collide_err", r, 32'h101);
        dmi(WR, 7'h16, 32'h700, r);

        // timeout
        done_delay = -1; n0 = en_total;
        dmi(WR, 7'h17, 32'h00221002, r);
        repeat (20) @(posedge clk);
        #1;
        chk("tmo_en_cycles", en_total - n0, AR_TIMEOUT);
        dmi(RD, 7'h16, 0, r); chk("tmo_err", r, 32'h301);
        dmi(WR, 7'h16, 32'h700, r);

        // dmactive=0 aborts and clears
        dmi(WR, 7'h17, 32'h00221002, r);
        dmi(WR, 7'h10, 32'h0, r);
        chk("abort_en", 32'(dbg_ar_en_o), 0);
        dmi(RD, 7'h04, 0, r); chk("abort_data0", r, 32'h0);
        dmi(RD, 7'h16, 0, r); chk("abort_acs", r, 32'h1);
        dmi(WR, 7'h10, 32'h1, r);
        dmi(WR, 7'h10, 32'h80000001, r);

        // resume
        dmi(WR, 7'h10, 32'h40000001, r);
        chk("resume_set", 32'(dbg_resumereq_o), 1);
        chk("resume_nohalt", 32'(dbg_haltreq_o), 0);
        repeat (3) @(posedge clk);
        #1;
        core_resumeack_i = 1'b1;
        core_halted_i = 1'b0; core_running_i = 1'b1;
        @(posedge clk);
        #1;
        core_resumeack_i = 1'b0;
        chk("resume_clr", 32'(dbg_resumereq_o), 0);
        dmi(RD, 7'h11, 0, r); chk("dmstatus_ack", r, 32'h30C82);
        dmi(WR, 7'h10, 32'hC0000001, r);
        chk("halt_wins_res", 32'(dbg_resumereq_o), 0);
        chk("halt_wins_halt", 32'(dbg_haltreq_o), 1);

        // async reset during EXEC
        core_halted_i = 1'b1; core_running_i = 1'b0;
        dmi(WR, 7'h17, 32'h00221002, r);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_en", 32'(dbg_ar_en_o), 1);
        #3;
        reset_i = 1'b1;
        #1;
        chk("arst_en", 32'(dbg_ar_en_o), 0);
        chk("arst_halt", 32'(dbg_haltreq_o), 0);
        chk("arst_ad", 32'(dbg_ar_ad_o), 0);
        chk("arst_ready", 32'(dmi_req_ready_o), 0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        dmi(RD, 7'h04, 0, r); chk("post_rst_d0", r, 32'h0);
        dmi(RD, 7'h10, 0, r); chk("post_rst_ctl", r, 32'h0);
        dmi(RD, 7'h16, 0, r); chk("post_rst_acs", r, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_abstract_ctrl.md
Name: dm_abstract_ctrl

Overview:
- Debug-module side of the core debug interface.
- Decodes DMI register accesses: data0, dmcontrol, dmstatus, abstractcs and command.
- Drives the core's halt/resume request lines and the abstract-register-access bus.
- Sits between the DTM/DMI transport and the core's debug FSM, sequencing Access Register commands and returning results in data0.

Parameters:
- AR_TIMEOUT, 16: cycles dbg_ar_en_o may stay high without dbg_ar_done_i before the command aborts.
- DM_VERSION, 2: value reported in dmstatus.version.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- dmi_req_valid_i  in  1  DMI request valid
- dmi_req_ready_o  out  1  DMI request accept
- dmi_op_i  in  2  1=read, 2=write, others=nop
- dmi_addr_i  in  7  DM register address
- dmi_data_i  in  32  write data
- dmi_resp_valid_o  out  1  response valid
- dmi_resp_ready_i  in  1  response accept
- dmi_resp_data_o  out  32  read data (0 for writes and nops)
- dbg_haltreq_o  out  1  halt request level
- dbg_resumereq_o  out  1  resume request, held until ack
- core_halted_i  in  1  core halted status
- core_running_i  in  1  core running status
- core_resumeack_i  in  1  resume acknowledge
- dbg_ar_en_o  out  1  abstract access strobe
- dbg_ar_wr_o  out  1  1=write register
- dbg_ar_ad_o  out  16  regno (CSR <0x1000, GPR 0x1000-0x101f)
- dbg_ar_do_o  out  32  write data to core (data0)
- dbg_ar_di_i  in  32  read data from core
- dbg_ar_done_i  in  1  access complete (may be same cycle as en)

Behaviour:
- Reset: all outputs 0; data0=0; dmcontrol=0; cmderr=0; busy=0; state IDLE.
- DMI handshake:
  - One transaction outstanding; dmi_req_ready_o = !dmi_resp_valid_o.
  - Request accepted at cycle T gives response valid at T+1, held until dmi_resp_ready_i.
- Registers:
  - 0x04 data0: R/W.
  - 0x10 dmcontrol: bit31 haltreq, bit30 resumereq (write-1 pulse), bit0 dmactive.
  - 0x11 dmstatus: read-only. [3:0]=DM_VERSION, bit7=1, bits9/8=core_halted_i, bits11/10=core_running_i, bits17/16=sticky resumeack.
  - 0x16 abstractcs: [3:0]=1, [10:8] cmderr (W1C), bit12 busy, [28:24]=0.
  - 0x17 command: write-only, reads 0.
  - Unmapped addresses read 0; writes to them are ignored.
- dmactive=0:
  - Holds data0, cmderr, haltreq, resumereq and sticky ack at 0.
  - Aborts any in-flight command: en dropped next cycle, state forced to IDLE.
  - Only dmactive itself is writable.
- dbg_haltreq_o = dmactive & dmcontrol.haltreq.
- Resume:
  - Writing resumereq=1 while haltreq=0 sets dbg_resumereq_o and clears sticky resumeack.
  - dbg_resumereq_o stays set until core_resumeack_i; that cycle it clears and sets sticky resumeack.
  - haltreq=1 and resumereq=1 in the same write: resumereq is ignored.
- Command write when cmderr!=0: ignored.
- Command write while busy: sets cmderr=1 and is ignored.
- Any data0 access while busy: sets cmderr=1; writes are dropped, reads return the current data0.
- Command decode (cmderr=0, not busy):
  - cmdtype[31:24]!=0, aarsize[22:20]!=2, or postexec[18]=1: cmderr=2 (not supported).
  - core_halted_i=0: cmderr=4.
  - transfer[17]=0: completes with no access.
  - Otherwise latch write[16] and regno[15:0], set busy, go to EXEC.
- FSM IDLE -> EXEC -> IDLE:
  - EXEC drives dbg_ar_en_o=1, dbg_ar_wr_o=write, dbg_ar_ad_o=regno, dbg_ar_do_o=data0.
  - On dbg_ar_done_i in EXEC: if read, data0 <= dbg_ar_di_i; then en=0, busy=0, return to IDLE.
  - Timeout counter resets on EXEC entry; reaching AR_TIMEOUT without done sets cmderr=3, busy=0, IDLE.
- Timing: command accepted at T -> en high at T+1. With same-cycle done, busy=0 and data0 updated at T+2.
- If a DMI write to data0 coincides with done, the core result wins and cmderr=1 is set.
- The async reset may assert in any state and returns all state to reset values.

Decomposition:
- dm_pkg holds:
  - register addresses (DM_DATA0, DM_DMCONTROL, DM_DMSTATUS, DM_ABSTRACTCS, DM_COMMAND)
  - cmderr enum (NONE=0, BUSY=1, NOTSUP=2, EXCEPT=3, HALTRESUME=4)
  - FSM state enum
  - command field bit positions
- Single module; no sub-module needed.

Test Plan:
- Write dmcontrol=0x80000001, core_halted_i rises; read dmstatus -> bits9/8=1, [3:0]=2, bit7=1.
- Halted core, data0=0xDEADBEEF, command=0x00231005 (write x5) -> en/wr=1, ad=0x1005, do=0xDEADBEEF for one cycle; busy drops at T+2.
- Halted core, command=0x00221002 (read x2), di=0x12345678 with done delayed 3 cycles -> data0 reads 0x12345678, cmderr=0.
- Running core, command=0x00221002 -> cmderr=4, no en; write abstractcs=0x700 -> cmderr=0.
- Commands 0x01221002 and 0x00321002 -> cmderr=2. A command write during busy -> cmderr=1. No done for 16 cycles -> cmderr=3.
- Halted core, write dmcontrol=0x40000001 -> resumereq high until ack; resumeack bits17/16=1. Assert reset_i mid-EXEC -> all outputs 0 asynchronously.
